// File: rtl/d3s_phase_nco_if.sv
// Control, tuning and phase-word bundle between the NCO and its neighbours.
// The master drives the controls and tuning word; the slave (the NCO) returns the phase words.
interface d3s_phase_nco_if;
    logic        enable_i;
    logic        sync_i;
    logic [31:0] ftw_i;
    logic        ftw_load_i;
    logic        ftw_ack_o;
    logic [31:0] phase_offset_i;
    logic [55:0] phase_divided_o;
    logic        phase_valid_o;
    logic        running_o;

    modport master (
        output enable_i, sync_i, ftw_i, ftw_load_i, phase_offset_i,
        input  ftw_ack_o, phase_divided_o, phase_valid_o, running_o
    );

    modport slave (
        input  enable_i, sync_i, ftw_i, ftw_load_i, phase_offset_i,
        output ftw_ack_o, phase_divided_o, phase_valid_o, running_o
    );
endinterface

// File: rtl/d3s_phase_nco.sv
// Four-lane NCO: the accumulator steps 4*FTW per clock, and lane k is (acc + k*FTW + offset)[31:18].
// Supports sync restart, optional arm-then-sync start and acknowledged FTW reload.
//
// state | meaning
// IDLE  | disabled, accumulator cleared, no output
// ARMED | enabled, waiting for sync_i before generating
// RUN   | generating one valid 4-lane word per clock
module d3s_phase_nco #(
    parameter int g_acc_bits   = 32,
    parameter int g_phase_bits = 14,
    parameter bit g_wait_sync  = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    d3s_phase_nco_if.slave bus_if
);
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                          state_q;
    logic [g_acc_bits-1:0]           acc_q;
    logic [g_acc_bits-1:0]           ftw_q;
    logic [g_acc_bits-1:0]           off_q;
    logic [LANES*g_phase_bits-1:0]   data_q;
    logic                            valid_q;
    logic                            ack_q;
    logic                            run_q;

    logic [g_acc_bits-1:0]           ftw_x2;
    logic [g_acc_bits-1:0]           ftw_x3;
    logic [g_acc_bits-1:0]           lane_sum [LANES];
    logic [LANES*g_phase_bits-1:0]   data_d;

    always_comb begin
        ftw_x2      = ftw_q << 1;
        ftw_x3      = ftw_q + ftw_x2;
        lane_sum[0] = acc_q + off_q;
        lane_sum[1] = acc_q + ftw_q + off_q;
        lane_sum[2] = acc_q + ftw_x2 + off_q;
        lane_sum[3] = acc_q + ftw_x3 + off_q;
        data_d      = '0;
        for (int k = 0; k < LANES; k++) begin
            data_d[k*g_phase_bits +: g_phase_bits] = lane_sum[k][g_acc_bits-1 -: g_phase_bits];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ftw_q   <= '0;
            off_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            off_q <= bus_if.phase_offset_i;
            ack_q <= bus_if.ftw_load_i;
            if (bus_if.ftw_load_i) begin
                ftw_q <= bus_if.ftw_i;
            end

            // The word leaving on this edge uses pre-edge acc, FTW and offset.
            if (bus_if.enable_i && state_q == S_RUN) begin
                data_q  <= data_d;
                valid_q <= 1'b1;
            end else begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end

            if (!bus_if.enable_i) begin
                state_q <= S_IDLE;
                acc_q   <= '0;
                run_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        acc_q   <= '0;
                        state_q <= g_wait_sync ? S_ARMED : S_RUN;
                        run_q   <= !g_wait_sync;
                    end
                    S_ARMED: begin
                        acc_q <= '0;
                        if (bus_if.sync_i) begin
                            state_q <= S_RUN;
                            run_q   <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        run_q <= 1'b1;
                        acc_q <= bus_if.sync_i ? '0 : acc_q + (ftw_q << 2);
                    end
                    default: begin
                        state_q <= S_IDLE;
                        acc_q   <= '0;
                        run_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_if.ftw_ack_o       = ack_q;
    assign bus_if.phase_divided_o = data_q;
    assign bus_if.phase_valid_o   = valid_q;
    assign bus_if.running_o       = run_q;
endmodule
